// File: rtl/life_pkg.sv
// Shared definitions for the life pattern loader: grid defaults, pattern
// character codes and the loader state encoding.
package life_pkg;

    localparam int WIDTH_DEF  = 17;
    localparam int HEIGHT_DEF = 17;
    localparam int CELL_NUM   = WIDTH_DEF * HEIGHT_DEF;

    localparam logic [7:0] CH_LIVE = 8'h23;
    localparam logic [7:0] CH_DEAD = 8'h2E;
    localparam logic [7:0] CH_NL   = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    // True for the three characters a pattern may contain.
    function automatic logic is_pattern_char(input logic [7:0] ch);
        return (ch == CH_LIVE) || (ch == CH_DEAD) || (ch == CH_NL);
    endfunction

endpackage

// File: rtl/life_pos_counter.sv
// Saturating row/column tracker for the pattern parser. Columns stop at
// WIDTH and rows stop at HEIGHT so over-long lines or extra rows never wrap
// back into the visible grid.
module life_pos_counter #(
    parameter int WIDTH  = 17,
    parameter int HEIGHT = 17,
    localparam int CW = $clog2(WIDTH + 1),
    localparam int RW = $clog2(HEIGHT + 1),
    localparam int IW = $clog2(WIDTH * HEIGHT)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          adv_col,
    input  logic          newline,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          in_range,
    output logic [IW-1:0] index
);

    // Track the cursor; clear wins, then newline, then column advance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (newline) begin
            if (row != RW'(HEIGHT)) begin
                row <= row + 1'b1;
            end
            col <= '0;
        end else if (adv_col) begin
            if (col != CW'(WIDTH)) begin
                col <= col + 1'b1;
            end
        end
    end

    // Linear cell index is only meaningful while the cursor is inside the grid.
    always_comb begin
        in_range = (row < RW'(HEIGHT)) && (col < CW'(WIDTH));
        index    = IW'(row) * IW'(WIDTH) + IW'(col);
    end

endmodule

// File: rtl/life_pattern_loader.sv
// Streaming parser that turns a '#', '.', '\n' byte stream into the life
// grid's initial-state vector and then strobes the grid's load input once.
module life_pattern_loader
    import life_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int HEIGHT = HEIGHT_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [WIDTH*HEIGHT-1:0]   init,
    output logic                      load,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [7:0]                err_row,
    output logic [7:0]                err_col
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(HEIGHT + 1);
    localparam int IW = $clog2(WIDTH * HEIGHT);

    state_t        state_q;
    state_t        state_d;
    logic          xfer;
    logic          ch_live;
    logic          ch_dead;
    logic          ch_nl;
    logic          ch_bad;
    logic          clear_pos;
    logic          adv_col;
    logic          newline;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          in_range;
    logic [IW-1:0] cell_idx;

    life_pos_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_pos (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear_pos),
        .adv_col  (adv_col),
        .newline  (newline),
        .row      (row),
        .col      (col),
        .in_range (in_range),
        .index    (cell_idx)
    );

    // Decode the incoming byte and the handshake; outputs follow state only.
    always_comb begin
        in_ready = (state_q == ST_RECV);
        load     = (state_q == ST_LOAD);
        busy     = (state_q == ST_RECV) || (state_q == ST_LOAD);
        error    = (state_q == ST_ERROR);
        xfer     = in_valid && in_ready;
        ch_live  = (in_data == CH_LIVE);
        ch_dead  = (in_data == CH_DEAD);
        ch_nl    = (in_data == CH_NL);
        ch_bad   = !is_pattern_char(in_data);
        adv_col  = xfer && (ch_live || ch_dead);
        newline  = xfer && ch_nl;
    end

    // Next-state logic; a start is only honoured when not busy.
    always_comb begin
        state_d   = state_q;
        clear_pos = 1'b0;
        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (start) begin
                    clear_pos = 1'b1;
                    state_d   = ST_RECV;
                end
            end
            ST_RECV: begin
                if (xfer) begin
                    if (ch_bad) begin
                        state_d = ST_ERROR;
                    end else if (in_last) begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Build the initial-state vector; it only changes in RECV or on a new start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            init <= '0;
        end else if (clear_pos) begin
            init <= '0;
        end else if (xfer && ch_live && in_range) begin
            init[cell_idx] <= 1'b1;
        end
    end

    // Remember where the first illegal byte was seen.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_row <= '0;
            err_col <= '0;
        end else if (xfer && ch_bad) begin
            err_row <= 8'(row);
            err_col <= 8'(col);
        end
    end

    // Completion pulse follows the single load cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= (state_q == ST_LOAD);
        end
    end

endmodule

// File: tb/tb_life_pattern_loader.sv
// Self-checking bench for life_pattern_loader: directed cases plus random
// byte streams compared against a simple cursor-walking reference model.
module tb_life_pattern_loader;

    localparam int W     = 17;
    localparam int H     = 17;
    localparam int CELLS = W * H;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_last;
    logic             in_ready;
    logic [CELLS-1:0] init;
    logic             load;
    logic             busy;
    logic             done;
    logic             error;
    logic [7:0]       err_row;
    logic [7:0]       err_col;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]       stream_q[$];
    logic [CELLS-1:0] exp_init;
    logic [CELLS-1:0] glider_mask;
    bit               exp_err;
    int               exp_er;
    int               exp_ec;
    int               exp_len;

    life_pattern_loader #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .init     (init),
        .load     (load),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_row  (err_row),
        .err_col  (err_col)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    // Hard stop in case the stimulus ever wedges.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkInit(input string tag, input logic [CELLS-1:0] expected);
        tests_run++;
        assert (init === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, init, expected);
        end
    endtask

    // Walk the stream with plain integers to predict the grid and any error.
    task automatic modelStream();
        int r = 0;
        int c = 0;
        exp_init = '0;
        exp_err  = 1'b0;
        exp_er   = 0;
        exp_ec   = 0;
        exp_len  = stream_q.size();
        for (int i = 0; i < stream_q.size(); i++) begin
            if (stream_q[i] == 8'h23) begin
                if (r < H && c < W) exp_init[r * W + c] = 1'b1;
                if (c < W) c++;
            end else if (stream_q[i] == 8'h2E) begin
                if (c < W) c++;
            end else if (stream_q[i] == 8'h0A) begin
                if (r < H) r++;
                c = 0;
            end else begin
                exp_err = 1'b1;
                exp_er  = r;
                exp_ec  = c;
                exp_len = i + 1;
                break;
            end
        end
    endtask

    task automatic setGlider();
        stream_q = '{8'h2E, 8'h23, 8'h2E, 8'h0A, 8'h2E, 8'h2E, 8'h23, 8'h0A, 8'h23, 8'h23, 8'h23};
    endtask

    // Start a load, stream stream_q in, then check the load/done or error outcome.
    task automatic applyStimulus(input string tag, input bit gaps, input bit poke_start);
        int  waited;
        bit  seen_pulse;
        modelStream();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checkOutput({tag, "_ready_after_start"}, in_ready, 1);
        for (int i = 0; i < exp_len; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                if (poke_start) start = 1'b1;
                @(negedge clock);
                start = 1'b0;
            end
            waited = 0;
            while (!in_ready && waited < 16) begin
                @(negedge clock);
                waited++;
            end
            if (waited >= 16) begin
                checkOutput({tag, "_ready_timeout"}, in_ready, 1);
                break;
            end
            in_valid = 1'b1;
            in_data  = stream_q[i];
            in_last  = (i == stream_q.size() - 1);
            @(negedge clock);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (exp_err) begin
            checkOutput({tag, "_error"}, error, 1);
            checkOutput({tag, "_err_ready"}, in_ready, 0);
            checkOutput({tag, "_err_row"}, err_row, exp_er);
            checkOutput({tag, "_err_col"}, err_col, exp_ec);
            checkInit({tag, "_err_init"}, exp_init);
            seen_pulse = 1'b0;
            for (int k = 0; k < 4; k++) begin
                seen_pulse |= (load | done);
                @(negedge clock);
            end
            checkOutput({tag, "_err_no_load"}, seen_pulse, 0);
            checkOutput({tag, "_err_hold"}, error, 1);
        end else begin
            checkOutput({tag, "_load"}, load, 1);
            checkOutput({tag, "_load_busy"}, busy, 1);
            checkOutput({tag, "_load_ready"}, in_ready, 0);
            checkOutput({tag, "_load_done_early"}, done, 0);
            checkInit({tag, "_init_at_load"}, exp_init);
            @(negedge clock);
            checkOutput({tag, "_load_end"}, load, 0);
            checkOutput({tag, "_done"}, done, 1);
            checkOutput({tag, "_done_busy"}, busy, 0);
            @(negedge clock);
            checkOutput({tag, "_done_end"}, done, 0);
            checkInit({tag, "_init_held"}, exp_init);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        glider_mask = '0;
        glider_mask[1]  = 1'b1;
        glider_mask[19] = 1'b1;
        glider_mask[34] = 1'b1;
        glider_mask[35] = 1'b1;
        glider_mask[36] = 1'b1;

        // Reset values.
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_load", load, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_err_row", err_row, 0);
        checkOutput("rst_err_col", err_col, 0);
        checkInit("rst_init", '0);

        // Glider, straight stream.
        setGlider();
        applyStimulus("glider", 1'b0, 1'b0);
        checkInit("glider_const", glider_mask);

        // Glider with valid gaps and ignored start pulses.
        setGlider();
        applyStimulus("glider_gaps", 1'b1, 1'b1);
        checkInit("glider_gaps_const", glider_mask);

        // Clipping of an over-long row.
        stream_q.delete();
        for (int i = 0; i < 20; i++) stream_q.push_back(8'h23);
        stream_q.push_back(8'h0A);
        stream_q.push_back(8'h23);
        applyStimulus("clip", 1'b0, 1'b0);
        checkInit("clip_const", CELLS'(36'h3_FFFF));

        // Invalid byte, then a fresh start clears the error and the grid.
        stream_q = '{8'h23, 8'h2E, 8'h78};
        applyStimulus("bad", 1'b0, 1'b0);
        checkOutput("bad_row_const", err_row, 0);
        checkOutput("bad_col_const", err_col, 2);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checkOutput("bad_restart_error", error, 0);
        checkOutput("bad_restart_ready", in_ready, 1);
        checkInit("bad_restart_init", '0);
        // Finish that load with an empty pattern.
        in_valid = 1'b1;
        in_data  = 8'h0A;
        in_last  = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("empty_load", load, 1);
        @(negedge clock);
        checkOutput("empty_done", done, 1);
        checkInit("empty_init", '0);

        // Asynchronous reset partway through a stream.
        setGlider();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = stream_q[i];
            in_last  = 1'b0;
            @(negedge clock);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        checkInit("midrst_init", '0);
        checkOutput("midrst_ready", in_ready, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_load", load, 0);
        checkOutput("midrst_done", done, 0);
        @(negedge clock);
        reset = 1'b0;
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 3; k++) begin
                seen |= (load | done);
                @(negedge clock);
            end
            checkOutput("midrst_no_pulse", seen, 0);
        end
        setGlider();
        applyStimulus("after_rst", 1'b0, 1'b0);
        checkInit("after_rst_const", glider_mask);

        // Row overflow: 18 newlines then a clipped live cell.
        stream_q.delete();
        for (int i = 0; i < 18; i++) stream_q.push_back(8'h0A);
        stream_q.push_back(8'h23);
        applyStimulus("rows_over", 1'b0, 1'b0);
        checkInit("rows_over_const", '0);

        // Random streams against the reference model.
        for (int t = 0; t < 25; t++) begin
            int len;
            len = $urandom_range(1, 60);
            stream_q.delete();
            for (int i = 0; i < len; i++) begin
                int sel;
                logic [7:0] b;
                sel = $urandom_range(0, 99);
                if (sel < 45)      b = 8'h23;
                else if (sel < 80) b = 8'h2E;
                else if (sel < 97) b = 8'h0A;
                else begin
                    b = 8'($urandom_range(0, 255));
                    while (b == 8'h23 || b == 8'h2E || b == 8'h0A) b = 8'($urandom_range(0, 255));
                end
                stream_q.push_back(b);
            end
            applyStimulus($sformatf("rand%0d", t), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
